// File: rtl/tinker_fetch_queue_if.sv
// Memory read port and instruction delivery port of the fetch queue.
// The queue drives the master side; memory and the core sit on the slave side.
interface tinker_fetch_queue_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [63:0] inst_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_word, inst_pc,
        input  mem_rvalid, mem_rdata, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_word, inst_pc,
        output mem_rvalid, mem_rdata, inst_ready
    );
endinterface

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: one outstanding 32-bit read, PC-tagged FIFO,
// registered head, flush-and-refetch on redirect.
module tinker_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic                     clk,
    input  logic                     reset,
    tinker_fetch_queue_if.master     bus,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    input  logic                     halt_in,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t        state, state_n;
    logic [63:0]   fetch_pc, fetch_pc_n;
    logic [63:0]   req_pc, req_pc_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW:0]   count, count_n;
    logic [31:0]   word_q [DEPTH];
    logic [63:0]   pc_q [DEPTH];
    logic [31:0]   head_word, head_word_n;
    logic [63:0]   head_pc, head_pc_n;
    logic          issue, push, pop;

    // Fetch sequencing: issue, wait for the reply, or drain a stale reply.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        issue      = 1'b0;
        push       = 1'b0;
        unique case (state)
            S_IDLE: begin
                issue = reset && !halt_in && !redirect_valid && (count < FULL);
                if (issue) begin
                    req_pc_n = fetch_pc;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    push       = !redirect_valid;
                    fetch_pc_n = req_pc + 64'd4;
                    state_n    = S_IDLE;
                end else if (redirect_valid) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (redirect_valid) fetch_pc_n = {redirect_pc[63:2], 2'b00};
        bus.mem_req  = issue;
        bus.mem_addr = issue ? fetch_pc : 64'd0;
    end

    // FIFO bookkeeping and the next value of the registered head entry.
    always_comb begin
        pop      = (count != '0) && bus.inst_ready && !redirect_valid;
        rd_ptr_n = rd_ptr + PW'(pop);
        wr_ptr_n = wr_ptr + PW'(push);
        count_n  = count + (PW+1)'(push) - (PW+1)'(pop);
        if (redirect_valid) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
        end
        head_word_n = word_q[rd_ptr_n];
        head_pc_n   = pc_q[rd_ptr_n];
        // A word landing in an otherwise empty queue becomes the head directly.
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_word_n = bus.mem_rdata;
            head_pc_n   = req_pc;
        end
        if (count_n == '0) begin
            head_word_n = '0;
            head_pc_n   = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Fetch address, pointers, count and head registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_word <= '0;
            head_pc   <= '0;
        end else begin
            fetch_pc  <= fetch_pc_n;
            req_pc    <= req_pc_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            head_word <= head_word_n;
            head_pc   <= head_pc_n;
        end
    end

    // Storage array; contents are qualified by the count, so no reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            word_q[wr_ptr] <= bus.mem_rdata;
            pc_q[wr_ptr]   <= req_pc;
        end
    end

    assign bus.inst_valid = (count != '0);
    assign bus.inst_word  = head_word;
    assign bus.inst_pc    = head_pc;
    assign occupancy      = count;
endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: directed scenarios plus random traffic,
// checked against a queue-based model of fetch order.
module tb_tinker_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt_in = 1'b0;
    logic [2:0]  occupancy;

    tinker_fetch_queue_if bus();

    tinker_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_in(halt_in),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [63:0] mq[$];
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_req_pc = '0;
    bit          m_out = 0;
    bit          m_stale = 0;

    int          resp_cnt = 0;
    logic [63:0] resp_addr = '0;
    int          lat = 1;
    int          n_req = 0;
    logic [63:0] last_addr = '0;
    logic [63:0] pop_log[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000 ^ {a[7:0], 24'h0} ^ a[63:32];
    endfunction

    task automatic step(input bit rdy, input bit rdr,
                        input logic [63:0] rpc, input bit hlt);
        bit exp_req;
        bit rv;
        bus.inst_ready = rdy;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        halt_in        = hlt;
        rv = 0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) rv = 1;
        end
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rv ? word_of(resp_addr) : 32'h0;
        @(negedge clk);
        exp_req = reset && !m_out && !hlt && !rdr && (mq.size() < DEPTH);
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        check("inst_valid", 64'(bus.inst_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("inst_pc", bus.inst_pc, mq[0]);
            check("inst_word", 64'(bus.inst_word), 64'(word_of(mq[0])));
        end
        check("mem_req", 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) check("mem_addr", bus.mem_addr, m_pc);
        if (bus.mem_req) begin
            resp_cnt  = lat;
            resp_addr = bus.mem_addr;
            last_addr = bus.mem_addr;
            n_req++;
        end
        if (!reset) begin
            mq.delete();
            m_pc    = RST_PC;
            m_out   = 0;
            m_stale = 0;
        end else if (rdr) begin
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
            if (m_out) begin
                if (rv) m_out = 0;
                else    m_stale = 1;
            end
        end else begin
            if (rdy && mq.size() != 0) begin
                pop_log.push_back(bus.inst_pc);
                void'(mq.pop_front());
            end
            if (rv && m_out) begin
                if (!m_stale) begin
                    mq.push_back(m_req_pc);
                    m_pc = m_req_pc + 64'd4;
                end
                m_out   = 0;
                m_stale = 0;
            end
            if (exp_req) begin
                m_out    = 1;
                m_stale  = 0;
                m_req_pc = m_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resp_cnt = 0;
        reset = 1'b0;
        repeat (2) step(0, 0, '0, 0);
        check("rst_addr", bus.mem_addr, 64'h0);
        reset = 1'b1;
        n_req = 0;
        pop_log.delete();
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        @(posedge clk);
        #1;

        // In-order delivery from reset at latency 1.
        lat = 1;
        do_reset();
        repeat (8) step(1, 0, '0, 0);
        check("first_addr", pop_log.size() > 0 ? pop_log[0] : 64'hX, 64'h2000);
        check("pop1", pop_log.size() > 1 ? pop_log[1] : 64'hX, 64'h2004);
        check("pop2", pop_log.size() > 2 ? pop_log[2] : 64'hX, 64'h2008);

        // Fill to DEPTH with the core stalled, then free one slot.
        do_reset();
        repeat (12) step(0, 0, '0, 0);
        check("fill_reqs", 64'(n_req), 64'd4);
        check("fill_occ", 64'(occupancy), 64'd4);
        check("fill_last", last_addr, 64'h200C);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        check("after_pop_addr", last_addr, 64'h2010);

        // Redirect while the request is in flight drains the stale word.
        lat = 3;
        do_reset();
        repeat (2) step(0, 0, '0, 0);
        step(0, 1, 64'h3001, 0);
        repeat (3) step(0, 0, '0, 0);
        check("drain_occ", 64'(occupancy), 64'd0);
        check("drain_addr", last_addr, 64'h3000);

        // Redirect coinciding with the reply and a pop request.
        lat = 1;
        do_reset();
        repeat (5) step(0, 0, '0, 0);
        check("pre_redir_occ", 64'(occupancy), 64'd2);
        step(1, 1, 64'h4000, 0);
        step(0, 0, '0, 0);
        check("redir_occ", 64'(occupancy), 64'd0);
        check("redir_addr", last_addr, 64'h4000);

        // Halt lets the in-flight word land but blocks new issues.
        lat = 3;
        do_reset();
        step(1, 0, '0, 0);
        repeat (6) step(1, 0, '0, 1);
        check("halt_reqs", 64'(n_req), 64'd1);
        check("halt_pop", pop_log.size() > 0 ? pop_log[0] : 64'hX, 64'h2000);
        step(1, 0, '0, 0);
        check("resume_addr", last_addr, 64'h2004);

        // Reset mid-request; the stale reply arrives in the first cycle after.
        lat = 2;
        do_reset();
        step(0, 0, '0, 0);
        reset = 1'b0;
        step(0, 0, '0, 0);
        reset = 1'b1;
        n_req = 0;
        step(0, 0, '0, 0);
        check("post_rst_addr", last_addr, 64'h2000);
        check("post_rst_occ", 64'(occupancy), 64'd0);
        repeat (3) step(0, 0, '0, 0);

        // Random traffic.
        begin
            bit hlt = 0;
            for (int i = 0; i < 3000; i++) begin
                bit rdr;
                logic [63:0] rpc;
                lat = $urandom_range(1, 3);
                if ($urandom_range(0, 9) == 0) hlt = !hlt;
                rdr = ($urandom_range(0, 29) == 0);
                rpc = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF5;
                step($urandom_range(0, 9) < 7, rdr, rpc, hlt);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
